// File: rtl/div_seq.sv
// Multi-cycle sequencer for 32-bit DIV/DIVU: radix-2 restoring divide over 32
// iterations with sign correction; returns {remainder, quotient}.
module div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        annul_i,
  input  logic        signed_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  output logic        busy_o,
  output logic        ready_o,
  output logic [63:0] result_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BYZERO = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_dvsMag;
  logic        r_signed;
  logic        r_dvdNeg;
  logic        r_dvsNeg;
  logic [63:0] r_result;

  logic        w_accept;
  logic [31:0] w_dvdMag;
  logic [31:0] w_dvsMag;
  logic [32:0] w_trial;
  logic [31:0] w_remNext;
  logic [31:0] w_quoNext;
  logic [31:0] w_remFinal;
  logic [31:0] w_quoFinal;

  assign w_accept = start_i & ~annul_i;

  assign w_dvdMag = (signed_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign w_dvsMag = (signed_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;

  // A clear borrow bit means the trial subtraction fits and the quotient bit is 1.
  assign w_trial   = {r_rem, r_quo[31]} - {1'b0, r_dvsMag};
  assign w_remNext = w_trial[32] ? {r_rem[30:0], r_quo[31]} : w_trial[31:0];
  assign w_quoNext = {r_quo[30:0], ~w_trial[32]};

  assign w_quoFinal = (r_signed && (r_dvdNeg ^ r_dvsNeg)) ? (~w_quoNext + 32'd1) : w_quoNext;
  assign w_remFinal = (r_signed && r_dvdNeg) ? (~w_remNext + 32'd1) : w_remNext;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= 5'd0;
      r_rem    <= 32'd0;
      r_quo    <= 32'd0;
      r_dvsMag <= 32'd0;
      r_signed <= 1'b0;
      r_dvdNeg <= 1'b0;
      r_dvsNeg <= 1'b0;
      r_result <= 64'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_signed <= signed_i;
            r_dvdNeg <= opdata1_i[31];
            r_dvsNeg <= opdata2_i[31];
            r_dvsMag <= w_dvsMag;
            r_cnt    <= 5'd0;
            r_rem    <= 32'd0;
            r_quo    <= w_dvdMag;
            if (opdata2_i == 32'd0) begin
              r_state <= BYZERO;
            end else begin
              r_state <= RUN;
            end
          end
        end
        BYZERO: begin
          if (annul_i) begin
            r_state <= IDLE;
          end else begin
            r_result <= 64'd0;
            r_state  <= DONE;
          end
        end
        RUN: begin
          if (annul_i) begin
            r_state <= IDLE;
            r_cnt   <= 5'd0;
          end else begin
            r_rem <= w_remNext;
            r_quo <= w_quoNext;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) begin
              r_result <= {w_remFinal, w_quoFinal};
              r_state  <= DONE;
            end
          end
        end
        // The owning instruction's start_i is still high here and must not re-trigger.
        DONE: begin
          r_state <= IDLE;
          r_cnt   <= 5'd0;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy_o   = ((r_state == IDLE) && start_i && !annul_i) ||
                    (r_state == RUN) || (r_state == BYZERO);
  assign ready_o  = (r_state == DONE);
  assign result_o = r_result;

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq: timing, sign handling, divide by
// zero, annul, operand latching, back-to-back and reset behaviour.
module tb_div_seq;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic        annul_i;
  logic        signed_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        busy_o;
  logic        ready_o;
  logic [63:0] result_o;

  int testsRun;
  int failures;

  logic        signTabS [3] = '{1'b1, 1'b1, 1'b0};
  logic [31:0] signTabA [3] = '{32'hFFFFFFF9, 32'd7, 32'hFFFFFFF9};
  logic [31:0] signTabB [3] = '{32'd2, 32'hFFFFFFFE, 32'd2};
  logic [63:0] signTabR [3] = '{{32'hFFFFFFFF, 32'hFFFFFFFD},
                                {32'h00000001, 32'hFFFFFFFD},
                                {32'h00000001, 32'h7FFFFFFC}};

  div_seq dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .annul_i   (annul_i),
    .signed_i  (signed_i),
    .opdata1_i (opdata1_i),
    .opdata2_i (opdata2_i),
    .busy_o    (busy_o),
    .ready_o   (ready_o),
    .result_o  (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_i = 1'b0;
    opdata1_i = 32'd0; opdata2_i = 32'd0;
    nextCycle();
    nextCycle();
    rst = 1'b0;
    @(negedge clk);
    testsRun += 3;
    if (busy_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got %b want 0", busy_o); end
    if (ready_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready got %b want 0", ready_o); end
    if (result_o !== 64'h0) begin failures++; $display("[TB] FAIL reset_result got %h want 0", result_o); end
  endtask

  task automatic test_unsigned();
    logic expBusy, expReady;
    nextCycle();
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
    for (int c = 0; c <= 34; c++) begin
      if (c == 34) start_i = 1'b0;
      @(negedge clk);
      expBusy  = (c <= 32);
      expReady = (c == 33);
      testsRun += 2;
      if (busy_o !== expBusy) begin failures++; $display("[TB] FAIL unsigned_busy c=%0d got %b want %b", c, busy_o, expBusy); end
      if (ready_o !== expReady) begin failures++; $display("[TB] FAIL unsigned_ready c=%0d got %b want %b", c, ready_o, expReady); end
      if (c >= 33) begin
        testsRun++;
        if (result_o !== {32'h2, 32'hE}) begin failures++; $display("[TB] FAIL unsigned_result c=%0d got %h want %h", c, result_o, {32'h2, 32'hE}); end
      end
      nextCycle();
    end
  endtask

  task automatic test_signs();
    int readyAt;
    logic [63:0] gotRes;
    for (int i = 0; i < 3; i++) begin
      start_i = 1'b1; signed_i = signTabS[i]; opdata1_i = signTabA[i]; opdata2_i = signTabB[i];
      readyAt = -1;
      gotRes = 64'h0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (ready_o === 1'b1 && readyAt < 0) begin readyAt = c; gotRes = result_o; end
        nextCycle();
        if (c == 33) start_i = 1'b0;
      end
      testsRun += 2;
      if (readyAt != 33) begin failures++; $display("[TB] FAIL signs_latency case=%0d got %0d want 33", i, readyAt); end
      if (gotRes !== signTabR[i]) begin failures++; $display("[TB] FAIL signs_result case=%0d got %h want %h", i, gotRes, signTabR[i]); end
    end
  endtask

  task automatic test_divzero();
    logic expBusy, expReady;
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd5; opdata2_i = 32'd0;
    for (int c = 0; c <= 3; c++) begin
      if (c == 3) start_i = 1'b0;
      @(negedge clk);
      expBusy  = (c <= 1);
      expReady = (c == 2);
      testsRun += 2;
      if (busy_o !== expBusy) begin failures++; $display("[TB] FAIL divzero_busy c=%0d got %b want %b", c, busy_o, expBusy); end
      if (ready_o !== expReady) begin failures++; $display("[TB] FAIL divzero_ready c=%0d got %b want %b", c, ready_o, expReady); end
      if (c == 2) begin
        testsRun++;
        if (result_o !== 64'h0) begin failures++; $display("[TB] FAIL divzero_result got %h want 0", result_o); end
      end
      nextCycle();
    end
  endtask

  task automatic test_annul();
    int readyAt;
    logic sawReady;
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
    for (int c = 0; c <= 10; c++) begin
      if (c == 10) annul_i = 1'b1;
      @(negedge clk);
      testsRun++;
      if (busy_o !== 1'b1) begin failures++; $display("[TB] FAIL annul_run_busy c=%0d got %b want 1", c, busy_o); end
      nextCycle();
    end
    // Cycle 11: the flushed instruction may linger; busy must be low only if back in IDLE.
    @(negedge clk);
    testsRun += 3;
    if (busy_o !== 1'b0) begin failures++; $display("[TB] FAIL annul_idle_busy got %b want 0", busy_o); end
    if (ready_o !== 1'b0) begin failures++; $display("[TB] FAIL annul_idle_ready got %b want 0", ready_o); end
    if (result_o !== 64'h0) begin failures++; $display("[TB] FAIL annul_result_kept got %h want 0", result_o); end
    nextCycle();
    start_i = 1'b0; annul_i = 1'b0;
    sawReady = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ready_o === 1'b1) sawReady = 1'b1;
      nextCycle();
    end
    testsRun += 2;
    if (sawReady !== 1'b0) begin failures++; $display("[TB] FAIL annul_no_ready got %b want 0", sawReady); end
    if (result_o !== 64'h0) begin failures++; $display("[TB] FAIL annul_result_after got %h want 0", result_o); end

    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'hFFFFFFFF; opdata2_i = 32'h10;
    readyAt = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 33) begin
        testsRun++;
        if (result_o !== {32'hF, 32'h0FFFFFFF}) begin failures++; $display("[TB] FAIL restart_result got %h want %h", result_o, {32'hF, 32'h0FFFFFFF}); end
      end
      if (ready_o === 1'b1 && readyAt < 0) readyAt = c;
      nextCycle();
      if (c == 33) start_i = 1'b0;
    end
    testsRun++;
    if (readyAt != 33) begin failures++; $display("[TB] FAIL restart_latency got %0d want 33", readyAt); end
  endtask

  task automatic test_overflow();
    int readyAt;
    start_i = 1'b1; signed_i = 1'b1; opdata1_i = 32'h80000000; opdata2_i = 32'hFFFFFFFF;
    readyAt = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 33) begin
        testsRun++;
        if (result_o !== {32'h0, 32'h80000000}) begin failures++; $display("[TB] FAIL overflow_result got %h want %h", result_o, {32'h0, 32'h80000000}); end
      end
      if (ready_o === 1'b1 && readyAt < 0) readyAt = c;
      nextCycle();
      if (c < 32) begin
        opdata1_i = $urandom;
        opdata2_i = $urandom;
        signed_i  = c[0];
      end
      if (c == 33) start_i = 1'b0;
    end
    testsRun++;
    if (readyAt != 33) begin failures++; $display("[TB] FAIL overflow_latency got %0d want 33", readyAt); end
  endtask

  task automatic test_back_to_back();
    logic expBusy, expReady;
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
    for (int c = 0; c <= 68; c++) begin
      if (c == 34) begin opdata1_i = 32'd50; opdata2_i = 32'd6; end
      if (c == 68) start_i = 1'b0;
      @(negedge clk);
      expBusy  = (c <= 32) || (c >= 34 && c <= 66);
      expReady = (c == 33) || (c == 67);
      testsRun += 2;
      if (busy_o !== expBusy) begin failures++; $display("[TB] FAIL b2b_busy c=%0d got %b want %b", c, busy_o, expBusy); end
      if (ready_o !== expReady) begin failures++; $display("[TB] FAIL b2b_ready c=%0d got %b want %b", c, ready_o, expReady); end
      if (c == 33) begin
        testsRun++;
        if (result_o !== {32'h2, 32'hE}) begin failures++; $display("[TB] FAIL b2b_first got %h want %h", result_o, {32'h2, 32'hE}); end
      end
      if (c == 67) begin
        testsRun++;
        if (result_o !== {32'h2, 32'h8}) begin failures++; $display("[TB] FAIL b2b_second got %h want %h", result_o, {32'h2, 32'h8}); end
      end
      nextCycle();
    end
  endtask

  task automatic test_reset_mid();
    logic sawReady;
    start_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
    for (int c = 0; c <= 20; c++) begin
      if (c == 20) rst = 1'b1;
      nextCycle();
    end
    rst = 1'b0; start_i = 1'b0;
    @(negedge clk);
    testsRun += 3;
    if (busy_o !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_busy got %b want 0", busy_o); end
    if (ready_o !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_ready got %b want 0", ready_o); end
    if (result_o !== 64'h0) begin failures++; $display("[TB] FAIL rstmid_result got %h want 0", result_o); end
    sawReady = 1'b0;
    for (int c = 0; c < 40; c++) begin
      nextCycle();
      @(negedge clk);
      if (ready_o === 1'b1) sawReady = 1'b1;
    end
    testsRun++;
    if (sawReady !== 1'b0) begin failures++; $display("[TB] FAIL rstmid_no_ready got %b want 0", sawReady); end
    nextCycle();
  endtask

  task automatic test_idle_guards();
    logic sawReady;
    start_i = 1'b1; annul_i = 1'b1; signed_i = 1'b0; opdata1_i = 32'd9; opdata2_i = 32'd3;
    @(negedge clk);
    testsRun++;
    if (busy_o !== 1'b0) begin failures++; $display("[TB] FAIL annul_idle_start_busy got %b want 0", busy_o); end
    nextCycle();
    start_i = 1'b0; annul_i = 1'b0;
    nextCycle();
    rst = 1'b1; start_i = 1'b1;
    nextCycle();
    rst = 1'b0; start_i = 1'b0;
    sawReady = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ready_o === 1'b1) sawReady = 1'b1;
      nextCycle();
    end
    testsRun++;
    if (sawReady !== 1'b0) begin failures++; $display("[TB] FAIL guard_no_accept got %b want 0", sawReady); end
  endtask

  initial begin
    testsRun = 0;
    failures = 0;
    test_reset();
    test_unsigned();
    test_signs();
    test_divzero();
    test_annul();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_idle_guards();
    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule

// File: doc/div_seq.md
# div_seq

Multi-cycle sequencer for the 32-bit integer divide path behind the EX stage. It accepts one DIV/DIVU request at a time, runs a radix-2 restoring divide over 32 iterations and applies sign correction. It returns {remainder, quotient} for the HI/LO write path. While a divide is in flight it raises a stall request toward the pipeline controller, and it supports annulment when the owning instruction is flushed.

## Interface
Parameters:
- none. Data width is fixed at 32, result width at 64.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-high
- start_i  input  1  divide request. Held by EX for as long as the instruction occupies EX.
- annul_i  input  1  flush of the owning instruction. Cancels a pending or running divide.
- signed_i  input  1  1 = DIV (two's complement), 0 = DIVU
- opdata1_i  input  32  dividend, sampled on accept only
- opdata2_i  input  32  divisor, sampled on accept only
- busy_o  output  1  stall request to the pipeline controller (combinational)
- ready_o  output  1  result valid, asserted for one cycle
- result_o  output  64  {remainder[63:32] -> HI, quotient[31:0] -> LO}

## Operation
States are IDLE, BYZERO, RUN and DONE. Reset enters IDLE.

IDLE:
- Accept occurs when start_i=1 and annul_i=0. On accept, latch signed_i and both operands.
- If opdata2_i==0, go to BYZERO. Otherwise go to RUN with cnt=0, R=0 and Q=|dividend|.
- Magnitude: |x| = (signed && x[31]) ? ~x+1 : x, taken as 32-bit unsigned.

RUN: one iteration per cycle.
- trial = {R[31:0], Q[31]} - {1'b0,|divisor|}, 33-bit.
- If trial[32]==0: R=trial[31:0] and Q={Q[30:0],1}.
- Else: R={R[30:0],Q[31]} and Q={Q[30:0],0}.
- cnt increments. When cnt==31, go to DONE.
- On the RUN->DONE edge, result_o is loaded:
  - quotient = (signed && dividend[31]^divisor[31]) ? ~Q+1 : Q
  - remainder = (signed && dividend[31]) ? ~Rfinal+1 : Rfinal
- The remainder's sign follows the dividend.

BYZERO:
- Load result_o=64'h0 and go to DONE.

DONE:
- ready_o=1 for exactly this cycle, then return to IDLE unconditionally.
- start_i is still high in DONE (the same instruction) and is ignored.
- A start_i seen in the following IDLE cycle belongs to a new instruction.

Annul:
- annul_i=1 in RUN or BYZERO: go to IDLE next cycle. ready_o never asserts and result_o is not updated.
- annul_i=1 in DONE: DONE still completes to IDLE. The consumer discards the result.

Outputs and registers:
- busy_o = (IDLE && start_i && !annul_i) || RUN || BYZERO. It is low in DONE so the pipeline advances in that cycle.
- ready_o = (state==DONE).
- result_o holds its value until the next completed divide.
- Operand changes after accept have no effect.

Overflow:
- Signed 0x80000000 / 0xFFFFFFFF yields Q=0x80000000, R=0 through natural 32-bit wrap. No trap.

Reset:
- Reset at any point, including mid-RUN, gives next cycle: state=IDLE, busy_o=0, ready_o=0, result_o=0, cnt=0.

## Timing
- Cycle 0 is the accept cycle; busy_o is already high in that cycle.
- Normal divide:
  - RUN occupies cycles 1..32 and DONE is cycle 33.
  - ready_o is high in cycle 33 with result_o valid.
  - busy_o is high in cycles 0..32.
  - Total latency is 33 cycles from accept to ready.
- Divide by zero:
  - BYZERO is cycle 1 and DONE is cycle 2.
  - busy_o is high in cycles 0..1.
- Back-to-back: earliest next accept is cycle 34, the IDLE cycle after DONE.
- Simultaneous rst and start_i: rst wins and nothing is accepted.
- Simultaneous start_i and annul_i in IDLE: not accepted, and busy_o=0.

## Test plan
- Unsigned 100/7, signed_i=0:
  - busy_o is high in cycles 0-32.
  - ready_o is high in cycle 33 only.
  - result_o = {32'h2, 32'hE}.
- Signed sign handling:
  - -7/2 gives result_o = {32'hFFFFFFFF, 32'hFFFFFFFD}.
  - 7/-2 gives result_o = {32'h1, 32'hFFFFFFFD}.
  - 0xFFFFFFF9/2 unsigned gives result_o = {32'h1, 32'h7FFFFFFC}.
- Divide by zero, 5/0:
  - busy_o is high in cycles 0-1.
  - ready_o is high in cycle 2.
  - result_o = 64'h0.
- Annul and restart:
  - Assert annul_i in cycle 10 of RUN. State is IDLE in cycle 11, busy_o=0, ready_o is never high, and result_o is unchanged.
  - Then start 0xFFFFFFFF/0x10 unsigned: result_o = {32'hF, 32'h0FFFFFFF} at accept+33.
- Signed overflow and operand latching:
  - Divide 0x80000000 / 0xFFFFFFFF signed while toggling opdata1_i/opdata2_i during RUN.
  - result_o = {32'h0, 32'h80000000}.
- Reset mid-operation:
  - Assert rst in cycle 20 of RUN. Next cycle busy_o=0, ready_o=0, result_o=0.
  - No ready_o follows.
